// File: rtl/cpu_ifetch.sv
// Instruction fetch reader: latches the PC, reads instruction memory with a
// req/ack handshake and holds one fetched word for the decoder.
module cpu_ifetch #(
  parameter int WAIT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       PC,
  output logic              PCWrite,
  input  logic              flush,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  output logic              inst_kernel,
  output logic              inst_fault,
  output logic [WAIT_W-1:0] wait_cycles
);

  typedef enum logic [1:0] {
    RESTART = 2'd0,
    FETCH   = 2'd1,
    FULL    = 2'd2
  } state_e;

  state_e            r_state;
  logic [31:0]       r_fetch_addr;
  logic              r_discard;
  logic [31:0]       r_inst;
  logic [31:0]       r_inst_pc;
  logic              r_inst_fault;
  logic              r_inst_valid;
  logic [WAIT_W-1:0] r_wait;

  logic w_fetch;
  logic w_drop;

  assign w_fetch = (r_state == FETCH);
  // A flush on the ack cycle means the word belongs to the abandoned path.
  assign w_drop  = r_discard | flush;

  assign PCWrite     = w_fetch & imem_ack & ~r_discard & ~flush;
  // Request is a pure decode of state so reset withdraws it asynchronously.
  assign imem_req    = w_fetch;
  assign imem_addr   = {1'b0, r_fetch_addr[30:2], 2'b00};
  assign inst_valid  = r_inst_valid;
  assign inst        = r_inst;
  assign inst_pc     = r_inst_pc;
  assign inst_kernel = r_inst_pc[31];
  assign inst_fault  = r_inst_fault;
  assign wait_cycles = r_wait;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= RESTART;
      r_fetch_addr <= '0;
      r_discard    <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_fault <= 1'b0;
      r_inst_valid <= 1'b0;
      r_wait       <= '0;
    end else begin
      case (r_state)
        RESTART: begin
          r_fetch_addr <= PC;
          if (|PC[1:0]) begin
            // Misaligned PC: hand the decoder a fault token without touching memory.
            r_inst       <= '0;
            r_inst_pc    <= PC;
            r_inst_fault <= 1'b1;
            r_inst_valid <= 1'b1;
            r_state      <= FULL;
          end else begin
            r_state <= FETCH;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            if (w_drop) begin
              r_discard <= 1'b0;
              r_state   <= RESTART;
            end else begin
              r_inst       <= imem_rdata;
              r_inst_pc    <= r_fetch_addr;
              r_inst_fault <= 1'b0;
              r_inst_valid <= 1'b1;
              r_state      <= FULL;
            end
          end else begin
            if (r_wait != '1) r_wait <= r_wait + WAIT_W'(1);
            if (flush) r_discard <= 1'b1;
          end
        end
        FULL: begin
          if (inst_ready | flush) begin
            r_inst_valid <= 1'b0;
            r_state      <= RESTART;
          end
        end
        default: r_state <= RESTART;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ifetch.sv
// Directed bench for cpu_ifetch with a tiny CPU_PC model (advance on PCWrite, load on flush).
module tb_cpu_ifetch;

  localparam int WAIT_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       PC;
  logic              PCWrite;
  logic              flush;
  logic              imem_req;
  logic [31:0]       imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;
  logic              inst_kernel;
  logic              inst_fault;
  logic [WAIT_W-1:0] wait_cycles;

  logic        pc_set;
  logic [31:0] pc_tgt;
  int          pw_cnt;
  int          req_cnt;
  int          vec;
  int          errs;
  int          r0;

  cpu_ifetch #(.WAIT_W(WAIT_W)) dut (
    .clk(clk), .reset(reset), .PC(PC), .PCWrite(PCWrite), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_kernel(inst_kernel),
    .inst_fault(inst_fault), .wait_cycles(wait_cycles)
  );

  always #5 clk = ~clk;

  // CPU_PC stand-in: redirect loads the target, otherwise advance on PCWrite.
  always @(posedge clk) begin
    if (flush | pc_set) PC <= pc_tgt;
    else if (PCWrite)   PC <= PC + 32'd4;
    if (PCWrite)  pw_cnt  <= pw_cnt + 1;
    if (imem_req) req_cnt <= req_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec = 0; errs = 0; pw_cnt = 0; req_cnt = 0;
    reset = 1'b0; flush = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    inst_ready = 1'b0; pc_set = 1'b1; pc_tgt = 32'h8000_0000; PC = '0;
    step(); step();
    #1;
    chk("rst_req",   32'(imem_req),    32'd0);
    chk("rst_valid", 32'(inst_valid),  32'd0);
    chk("rst_pcw",   32'(PCWrite),     32'd0);
    chk("rst_wait",  32'(wait_cycles), 32'd0);
    chk("rst_addr",  imem_addr,        32'h0);
    chk("rst_pc",    PC,               32'h8000_0000);
    pw_cnt = 0; req_cnt = 0;

    // First fetch, zero-wait memory
    pc_set = 1'b0; reset = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'h3C01_1234;
    #1 chk("restart_noreq", 32'(imem_req), 32'd0);
    chk("restart_pcw", 32'(PCWrite), 32'd0);
    step(); #1;
    chk("f1_req",  32'(imem_req), 32'd1);
    chk("f1_addr", imem_addr,     32'h0000_0000);
    chk("f1_pcw",  32'(PCWrite),  32'd1);
    step(); imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF; #1;
    chk("f1_valid",  32'(inst_valid),  32'd1);
    chk("f1_inst",   inst,             32'h3C01_1234);
    chk("f1_ipc",    inst_pc,          32'h8000_0000);
    chk("f1_kern",   32'(inst_kernel), 32'd1);
    chk("f1_fault",  32'(inst_fault),  32'd0);
    chk("f1_pcw_lo", 32'(PCWrite),     32'd0);
    chk("f1_pwcnt",  pw_cnt,           32'd1);

    // Backpressure: output register holds, no new request
    for (int i = 0; i < 6; i++) begin
      chk("bp_req",   32'(imem_req),   32'd0);
      chk("bp_valid", 32'(inst_valid), 32'd1);
      chk("bp_inst",  inst,            32'h3C01_1234);
      chk("bp_ipc",   inst_pc,         32'h8000_0000);
      step(); #1;
    end
    inst_ready = 1'b1;
    step(); inst_ready = 1'b0; #1;
    chk("acc_valid", 32'(inst_valid), 32'd0);
    chk("acc_req",   32'(imem_req),   32'd0);
    r0 = req_cnt;
    step(); #1;

    // Wait states: ack on the 5th request cycle
    for (int i = 0; i < 4; i++) begin
      chk("ws_req",  32'(imem_req), 32'd1);
      chk("ws_addr", imem_addr,     32'h0000_0004);
      chk("ws_pcw",  32'(PCWrite),  32'd0);
      step(); #1;
    end
    imem_ack = 1'b1; imem_rdata = 32'h2402_0005; #1;
    chk("ws_pcw_ack", 32'(PCWrite), 32'd1);
    step(); imem_ack = 1'b0; #1;
    chk("ws_reqcyc", req_cnt - r0,  32'd5);
    chk("ws_wait",   wait_cycles,   32'd4);
    chk("ws_pwcnt",  pw_cnt,        32'd2);
    chk("ws_inst",   inst,          32'h2402_0005);
    chk("ws_ipc",    inst_pc,       32'h8000_0004);
    inst_ready = 1'b1;
    step(); inst_ready = 1'b0; #1;
    step(); #1;

    // Flush in flight: flush on the 2nd wait cycle, ack two cycles later
    chk("fl_addr0", imem_addr, 32'h0000_0008);
    step(); #1;
    flush = 1'b1; pc_tgt = 32'h0000_0080; #1;
    chk("fl_pcw_fl", 32'(PCWrite), 32'd0);
    step(); flush = 1'b0; #1;
    chk("fl_req_held", 32'(imem_req), 32'd1);
    chk("fl_addr_held", imem_addr,    32'h0000_0008);
    step(); imem_ack = 1'b1; imem_rdata = 32'h1111_1111; #1;
    chk("fl_pcw_ack", 32'(PCWrite), 32'd0);
    step(); imem_ack = 1'b0; #1;
    chk("fl_valid", 32'(inst_valid), 32'd0);
    chk("fl_req",   32'(imem_req),   32'd0);
    step(); #1;
    chk("fl_newaddr", imem_addr,   32'h0000_0080);
    chk("fl_wait",    wait_cycles, 32'd7);
    chk("fl_pwcnt",   pw_cnt,      32'd2);

    // Flush coincident with ack
    flush = 1'b1; imem_ack = 1'b1; pc_tgt = 32'h0000_0100; #1;
    chk("fa_pcw", 32'(PCWrite), 32'd0);
    step(); flush = 1'b0; imem_ack = 1'b0; #1;
    chk("fa_valid", 32'(inst_valid), 32'd0);
    chk("fa_req",   32'(imem_req),   32'd0);
    step(); #1;
    chk("fa_addr", imem_addr, 32'h0000_0100);
    imem_ack = 1'b1; imem_rdata = 32'h8C22_0010;
    step(); imem_ack = 1'b0; #1;
    chk("fa_inst", inst,             32'h8C22_0010);
    chk("fa_ipc",  inst_pc,          32'h0000_0100);
    chk("fa_kern", 32'(inst_kernel), 32'd0);

    // Misaligned fetch after redirect from FULL
    flush = 1'b1; pc_tgt = 32'h0000_0402;
    step(); flush = 1'b0; #1;
    chk("mis_restart_req", 32'(imem_req), 32'd0);
    step(); #1;
    for (int i = 0; i < 3; i++) begin
      chk("mis_req", 32'(imem_req), 32'd0);
      chk("mis_pcw", 32'(PCWrite),  32'd0);
      step(); #1;
    end
    chk("mis_valid", 32'(inst_valid), 32'd1);
    chk("mis_fault", 32'(inst_fault), 32'd1);
    chk("mis_inst",  inst,            32'h0);
    chk("mis_ipc",   inst_pc,         32'h0000_0402);
    flush = 1'b1; pc_tgt = 32'h8000_0008;
    step(); flush = 1'b0; #1;
    chk("mis_fl_valid", 32'(inst_valid), 32'd0);
    step(); #1;
    chk("mis_re_addr", imem_addr,     32'h0000_0008);
    chk("mis_re_req",  32'(imem_req), 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'h0000_000C;
    step(); imem_ack = 1'b0; #1;
    chk("mis_re_fault", 32'(inst_fault),  32'd0);
    chk("mis_re_ipc",   inst_pc,          32'h8000_0008);
    chk("mis_re_kern",  32'(inst_kernel), 32'd1);
    chk("mis_re_inst",  inst,             32'h0000_000C);
    chk("tot_pwcnt",    pw_cnt,           32'd4);
    inst_ready = 1'b1;
    step(); inst_ready = 1'b0; #1;
    step(); #1;

    // Asynchronous reset in the middle of a request
    chk("ar_req_pre", 32'(imem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_req",   32'(imem_req),    32'd0);
    chk("ar_pcw",   32'(PCWrite),     32'd0);
    chk("ar_wait",  32'(wait_cycles), 32'd0);
    chk("ar_valid", 32'(inst_valid),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/cpu_ifetch.md
# cpu_ifetch

Instruction fetch reader for the PC produced by CPU_PC. It latches the current PC, reads the instruction memory with a req/ack handshake, and holds the fetched word in a one-entry output register for the decoder. It pulses `PCWrite` so CPU_PC advances only after a word is captured, and discards in-flight data when control flow is redirected.

## Interface
- `WAIT_W`, default 16: width of the saturating wait-cycle counter.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `PC` in 32: current PC from CPU_PC; bit 31 is the kernel/supervisor flag.
- `PCWrite` out 1: combinational advance strobe to CPU_PC.
- `flush` in 1: redirect strobe, asserted in the cycle CPU_PC loads a branch, jump, JR, ILLOP or XADR target.
- `imem_req` out 1: instruction memory read request.
- `imem_addr` out 32: word-aligned memory address.
- `imem_ack` in 1: read data valid, sampled at the rising edge.
- `imem_rdata` in 32: instruction word.
- `inst_valid` out 1: output register holds an instruction.
- `inst_ready` in 1: decoder accepts the output register.
- `inst` out 32: fetched instruction.
- `inst_pc` out 32: PC of `inst`.
- `inst_kernel` out 1: `inst_pc[31]`.
- `inst_fault` out 1: misaligned-fetch fault attached to `inst`.
- `wait_cycles` out WAIT_W: saturating count of cycles spent with `imem_req`=1 and `imem_ack`=0.

## Operation
- Registers:
  - `fetch_addr[31:0]`
  - `discard`
  - output register (`inst`, `inst_pc`, `inst_fault`, `inst_valid`)
  - `wait_cycles`
  - 2-bit state: RESTART, FETCH, FULL.
- Reset (reset=0, asynchronous):
  - State becomes RESTART.
  - All outputs and registers go to 0, including `imem_req`, `PCWrite` and `inst_valid`.
- RESTART (1 cycle, no request):
  - `fetch_addr` <= PC.
  - If PC[1:0]≠0: load the output register with `inst`=0, `inst_pc`=PC, `inst_fault`=1 and `inst_valid`=1, then go to FULL. No `PCWrite` and no memory request.
  - Otherwise go to FETCH.
- FETCH:
  - `imem_req`=1 and `imem_addr`={1'b0, fetch_addr[30:2], 2'b00}.
  - `imem_req` stays high until `imem_ack`. A request is never withdrawn, except by reset.
  - On `imem_ack` with discard=0 and flush=0:
    - `inst` <= `imem_rdata`, `inst_pc` <= `fetch_addr`, `inst_fault` <= 0, `inst_valid` <= 1.
    - `PCWrite`=1 in this cycle.
    - Go to FULL.
  - On `imem_ack` with discard=1 or flush=1: the data is dropped, `PCWrite`=0, discard <= 0, go to RESTART.
  - `flush` without `imem_ack`: discard <= 1 and stay in FETCH.
- FULL:
  - `inst_valid`=1. The output register is stable while `inst_ready`=0.
  - When `inst_ready`=1 or `flush`=1: `inst_valid` <= 0 and go to RESTART.
- `PCWrite` = (state==FETCH) & imem_ack & ~discard & ~flush, with no other term. Flush has priority over advance.
- `wait_cycles` increments while in FETCH with `imem_ack`=0, saturates at all-ones, and clears only on reset.

## Timing
- Latency:
  - Minimum, zero-wait memory: RESTART → FETCH (ack in the same cycle) → FULL, so `inst_valid` rises 2 cycles after leaving reset.
  - Peak throughput is one instruction per 3 cycles with `inst_ready` held high.
- PC handoff: CPU_PC updates on the same edge that captures `inst`. The new PC is sampled in the following RESTART cycle, so there is no combinational path from PC to `imem_addr`.
- Simultaneous events:
  - flush + ack in FETCH: data dropped.
  - flush + inst_ready in FULL: the instruction counts as accepted, then RESTART.
- Reset mid-FETCH: `imem_req` drops asynchronously. The memory must abandon the read, and no `PCWrite` is produced.
- `inst_kernel` always equals `inst_pc[31]`. `imem_addr[31]` is always 0.

## Test plan
- Reset and first fetch:
  - Stimulus: PC=0x80000000, reset released, ack in the same cycle, rdata=0x3C011234.
  - Required: `imem_addr`=0x00000000; `inst`=0x3C011234, `inst_pc`=0x80000000, `inst_kernel`=1; `PCWrite` high exactly 1 cycle.
- Wait states:
  - Stimulus: ack delayed 4 cycles.
  - Required: `imem_req` held 5 cycles, `wait_cycles`=4, a single `PCWrite` pulse.
- Backpressure:
  - Stimulus: `inst_ready`=0 for 6 cycles after `inst_valid`.
  - Required: no new `imem_req`; `inst`/`inst_pc` stable; after ready, next fetch at PC=0x80000004.
- Flush in flight:
  - Stimulus: flush in the 2nd wait cycle, PC→0x00000080, ack 2 cycles later.
  - Required: data dropped, no `PCWrite`; next `imem_addr`=0x00000080.
- Flush with ack:
  - Stimulus: flush and ack in the same cycle.
  - Required: `PCWrite`=0, `inst_valid` stays 0.
- Misaligned fetch:
  - Stimulus: PC=0x00000402.
  - Required: no `imem_req`; `inst_valid`=1, `inst_fault`=1, `inst`=0; after flush to 0x80000008, a normal fetch from `imem_addr` 0x00000008.
